// File: rtl/m6809e_bus_sequencer_if.sv
// CPU-side bus bundle for the 6809E bus sequencer: address/status in, E/Q clocks and strobes out.
// The sequencer uses the slave view; whatever drives the CPU pins uses the master view.
interface m6809e_bus_sequencer_if;
    logic       decode_fe_b;
    logic [2:0] a7_5;
    logic       a8;
    logic       bs;
    logic       ba;
    logic       sys_mrdy;
    logic       eclk;
    logic       qclk;
    logic       sys_a8;
    logic       csuart_b;
    logic       csio_b;
    logic       iack_b;
    logic       stretch_to;

    modport master (
        output decode_fe_b, a7_5, a8, bs, ba, sys_mrdy,
        input  eclk, qclk, sys_a8, csuart_b, csio_b, iack_b, stretch_to
    );

    modport slave (
        input  decode_fe_b, a7_5, a8, bs, ba, sys_mrdy,
        output eclk, qclk, sys_a8, csuart_b, csio_b, iack_b, stretch_to
    );
endinterface

// File: rtl/m6809e_bus_sequencer.sv
// 6809E E/Q clock generator and bus-cycle sequencer with page-FE I/O stretch,
// MRDY stretch with timeout, registered chip selects, vector A8 remap and IACK.
module m6809e_bus_sequencer #(
    parameter int DIV         = 4,
    parameter int IO_WAIT     = 2,
    parameter int MAX_STRETCH = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    m6809e_bus_sequencer_if.slave        bus
);
    localparam int DW = $clog2(DIV);
    localparam int SW = (MAX_STRETCH < 2) ? 1 : $clog2(MAX_STRETCH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] IO_HOLD  = SW'(IO_WAIT * DIV);
    localparam logic [SW-1:0] MAX_HOLD = SW'(MAX_STRETCH);

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    phase_t        phase_q, phase_d;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          fe_q, fe_d;
    logic          uart_q, uart_d;
    logic          io_q, io_d;
    logic          vec_q, vec_d;
    logic          eclk_q, eclk_d;
    logic          qclk_q, qclk_d;
    logic          csuart_b_q, csuart_b_d;
    logic          csio_b_q, csio_b_d;
    logic          iack_b_q, iack_b_d;
    logic          stretch_to_q, stretch_to_d;
    logic          rdy_m_q, rdy_s_q;
    logic          hold;

    always_comb begin
        phase_d      = phase_q;
        div_d        = div_q;
        scnt_d       = scnt_q;
        fe_d         = fe_q;
        uart_d       = uart_q;
        io_d         = io_q;
        vec_d        = vec_q;
        stretch_to_d = 1'b0;
        hold         = (fe_q && (scnt_q < IO_HOLD)) || !rdy_s_q;

        // P3 parks on its last divider count while held; the timeout overrides hold
        if (div_q != DIV_LAST) begin
            div_d = div_q + DW'(1);
        end else if ((phase_q == P3) && hold && (scnt_q != MAX_HOLD)) begin
            scnt_d = scnt_q + SW'(1);
        end else begin
            div_d        = '0;
            stretch_to_d = (phase_q == P3) && hold;
            case (phase_q)
                P0:      phase_d = P1;
                P1:      phase_d = P2;
                P2:      phase_d = P3;
                default: phase_d = P0;
            endcase
        end

        if (phase_q == P1) begin
            fe_d   = !bus.decode_fe_b && !bus.ba;
            uart_d = fe_d && (bus.a7_5 == 3'd0);
            io_d   = fe_d && (bus.a7_5 == 3'd1);
            vec_d  = bus.bs && !bus.ba;
        end

        if ((phase_q == P3) && (phase_d == P0)) begin
            fe_d   = 1'b0;
            uart_d = 1'b0;
            io_d   = 1'b0;
            vec_d  = 1'b0;
            scnt_d = '0;
        end

        // Outputs follow the next phase so the pins line up with phase_q
        eclk_d     = (phase_d == P2) || (phase_d == P3);
        qclk_d     = (phase_d == P1) || (phase_d == P2);
        csuart_b_d = !uart_d;
        csio_b_d   = !io_d;
        iack_b_d   = !(vec_d && eclk_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= P0;
            div_q        <= '0;
            scnt_q       <= '0;
            fe_q         <= 1'b0;
            uart_q       <= 1'b0;
            io_q         <= 1'b0;
            vec_q        <= 1'b0;
            eclk_q       <= 1'b0;
            qclk_q       <= 1'b0;
            csuart_b_q   <= 1'b1;
            csio_b_q     <= 1'b1;
            iack_b_q     <= 1'b1;
            stretch_to_q <= 1'b0;
            rdy_m_q      <= 1'b1;
            rdy_s_q      <= 1'b1;
        end else begin
            phase_q      <= phase_d;
            div_q        <= div_d;
            scnt_q       <= scnt_d;
            fe_q         <= fe_d;
            uart_q       <= uart_d;
            io_q         <= io_d;
            vec_q        <= vec_d;
            eclk_q       <= eclk_d;
            qclk_q       <= qclk_d;
            csuart_b_q   <= csuart_b_d;
            csio_b_q     <= csio_b_d;
            iack_b_q     <= iack_b_d;
            stretch_to_q <= stretch_to_d;
            rdy_m_q      <= bus.sys_mrdy;
            rdy_s_q      <= rdy_m_q;
        end
    end

    assign bus.eclk       = eclk_q;
    assign bus.qclk       = qclk_q;
    assign bus.csuart_b   = csuart_b_q;
    assign bus.csio_b     = csio_b_q;
    assign bus.iack_b     = iack_b_q;
    assign bus.stretch_to = stretch_to_q;
    // Vector fetch moves the CPU's $FFxx vectors to the $FExx page on the backplane
    assign bus.sys_a8     = bus.a8 ^ (bus.bs & ~bus.ba);
endmodule

// File: tb/tb_m6809e_bus_sequencer.sv
// Bench for m6809e_bus_sequencer: cycle-position model checked every HSCLK plus
// hand-computed per-bus-cycle expectations (E/Q widths, select/IACK widths, timeouts, reset).
module tb_m6809e_bus_sequencer;
    localparam int DIV         = 4;
    localparam int IO_WAIT     = 2;
    localparam int MAX_STRETCH = 40;
    localparam int LAST        = 4 * DIV - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m6809e_bus_sequencer_if bus_if ();

    m6809e_bus_sequencer #(
        .DIV         (DIV),
        .IO_WAIT     (IO_WAIT),
        .MAX_STRETCH (MAX_STRETCH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the HSCLK position inside the current bus cycle (0 = first E-low/Q-low clock).
    int m_t;
    bit m_fe, m_uart, m_io, m_vec, m_to, m_s1, m_s2;

    function automatic bit m_hold();
        return (m_fe && ((m_t - LAST) < IO_WAIT * DIV)) || !m_s2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0; m_fe <= 0; m_uart <= 0; m_io <= 0; m_vec <= 0;
            m_to <= 0; m_s1 <= 1; m_s2 <= 1;
        end else begin
            m_s1 <= bus_if.sys_mrdy;
            m_s2 <= m_s1;
            m_to <= 0;
            if (m_t < LAST) begin
                m_t <= m_t + 1;
                if (m_t >= DIV && m_t < 2 * DIV) begin
                    m_fe   <= !bus_if.decode_fe_b && !bus_if.ba;
                    m_uart <= !bus_if.decode_fe_b && !bus_if.ba && (bus_if.a7_5 == 3'd0);
                    m_io   <= !bus_if.decode_fe_b && !bus_if.ba && (bus_if.a7_5 == 3'd1);
                    m_vec  <= bus_if.bs && !bus_if.ba;
                end
            end else if (m_hold() && (m_t - LAST) < MAX_STRETCH) begin
                m_t <= m_t + 1;
            end else begin
                m_to <= m_hold();
                m_t <= 0; m_fe <= 0; m_uart <= 0; m_io <= 0; m_vec <= 0;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("eclk",       int'(bus_if.eclk),       int'(m_t >= 2 * DIV));
            chk("qclk",       int'(bus_if.qclk),       int'(m_t >= DIV && m_t < 3 * DIV));
            chk("csuart_b",   int'(bus_if.csuart_b),   int'(!m_uart));
            chk("csio_b",     int'(bus_if.csio_b),     int'(!m_io));
            chk("iack_b",     int'(bus_if.iack_b),     int'(!(m_vec && m_t >= 2 * DIV)));
            chk("stretch_to", int'(bus_if.stretch_to), int'(m_to));
            chk("sys_a8",     int'(bus_if.sys_a8),
                int'(bus_if.a8 ^ (bus_if.bs & ~bus_if.ba)));
        end
    end

    typedef struct {
        int e_low; int e_high; int q_lead; int cs_u; int cs_io; int iack; int to_n;
    } cyc_t;

    // Call at the first clock of a bus cycle; returns at the first clock of the next one.
    task automatic bus_cycle(output cyc_t r);
        bit seen_hi;
        bit done;
        int q_rise;
        int e_rise;
        seen_hi = 0; done = 0; q_rise = -1; e_rise = -1;
        r = '{default: 0};
        for (int n = 0; n < 400 && !done; n++) begin
            if (bus_if.eclk) begin
                if (!seen_hi) e_rise = n;
                seen_hi = 1;
                r.e_high++;
            end else if (seen_hi) begin
                r.to_n = int'(bus_if.stretch_to);
                done = 1;
            end else begin
                r.e_low++;
            end
            if (!done) begin
                if (bus_if.qclk && q_rise < 0) q_rise = n;
                if (!bus_if.csuart_b) r.cs_u++;
                if (!bus_if.csio_b) r.cs_io++;
                if (!bus_if.iack_b) r.iack++;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL bus_cycle_timeout: got no E fall want one within 400 clocks at %0t", $time);
        end
        r.q_lead = e_rise - q_rise;
    endtask

    task automatic chk_cycle(input string tag, input cyc_t r, input int e_low, input int e_high,
                             input int cs_u, input int cs_io, input int iack, input int to_n);
        chk({tag, "_e_low"},  r.e_low,  e_low);
        chk({tag, "_e_high"}, r.e_high, e_high);
        chk({tag, "_q_lead"}, r.q_lead, DIV);
        chk({tag, "_csuart"}, r.cs_u,   cs_u);
        chk({tag, "_csio"},   r.cs_io,  cs_io);
        chk({tag, "_iack"},   r.iack,   iack);
        chk({tag, "_to"},     r.to_n,   to_n);
    endtask

    task automatic drive(input bit fe_b, input int a75, input bit a8, input bit bs,
                         input bit ba, input bit mrdy);
        #1;
        bus_if.decode_fe_b = fe_b;
        bus_if.a7_5        = 3'(a75);
        bus_if.a8          = a8;
        bus_if.bs          = bs;
        bus_if.ba          = ba;
        bus_if.sys_mrdy    = mrdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t r;
        rst = 1'b1;
        bus_if.decode_fe_b = 1; bus_if.a7_5 = 0; bus_if.a8 = 0;
        bus_if.bs = 0; bus_if.ba = 0; bus_if.sys_mrdy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_eclk", int'(bus_if.eclk), 0);
        chk("rst_qclk", int'(bus_if.qclk), 0);
        chk("rst_csuart", int'(bus_if.csuart_b), 1);
        chk("rst_csio", int'(bus_if.csio_b), 1);
        chk("rst_iack", int'(bus_if.iack_b), 1);
        chk("rst_to", int'(bus_if.stretch_to), 0);
        @(posedge clk); #1 rst = 1'b0; chk_en = 1;
        @(negedge clk);

        // Plain cycle: 16-clock E period, 8 high, Q leads by DIV
        bus_cycle(r); chk_cycle("t1", r, 8, 8, 0, 0, 0, 0);
        $display("t1 plain: e_low=%0d e_high=%0d q_lead=%0d", r.e_low, r.e_high, r.q_lead);

        // UART access: fixed 8-clock stretch, select low from P1+1 to end of E
        drive(0, 0, 0, 0, 0, 1);
        bus_cycle(r); chk_cycle("t2", r, 8, 16, 19, 0, 0, 0);
        $display("t2 uart: e_high=%0d csuart_low=%0d", r.e_high, r.cs_u);

        // IO access with MRDY low 30 clocks from mid-P2
        drive(0, 1, 0, 0, 0, 1);
        fork
            bus_cycle(r);
            begin
                repeat (10) @(negedge clk);
                #1 bus_if.sys_mrdy = 0;
                repeat (30) @(negedge clk);
                #1 bus_if.sys_mrdy = 1;
            end
        join
        chk_cycle("t3", r, 8, 35, 0, 38, 0, 0);
        $display("t3 io+mrdy: e_high=%0d csio_low=%0d to=%0d", r.e_high, r.cs_io, r.to_n);

        // MRDY stuck low: timeout after MAX_STRETCH held clocks, then a normal cycle
        drive(1, 0, 0, 0, 0, 0);
        bus_cycle(r); chk_cycle("t4", r, 8, 8 + MAX_STRETCH, 0, 0, 0, 1);
        $display("t4 timeout: e_high=%0d to=%0d", r.e_high, r.to_n);
        drive(1, 0, 0, 0, 0, 1);
        bus_cycle(r); chk_cycle("t4n", r, 8, 8, 0, 0, 0, 0);
        $display("t4n after timeout: e_high=%0d to=%0d", r.e_high, r.to_n);

        // Vector fetch: A8 inverted, IACK for the E-high window only
        drive(1, 0, 0, 1, 0, 1);
        #1 chk("t5_sys_a8_vec", int'(bus_if.sys_a8), 1);
        bus_cycle(r); chk_cycle("t5", r, 8, 8, 0, 0, 8, 0);
        $display("t5 vector: sys_a8 remap iack_low=%0d", r.iack);
        drive(1, 0, 0, 1, 1, 1);
        #1 chk("t5b_sys_a8", int'(bus_if.sys_a8), 0);
        bus_cycle(r); chk_cycle("t5b", r, 8, 8, 0, 0, 0, 0);
        $display("t5b bs+ba: iack_low=%0d", r.iack);
        drive(0, 0, 1, 1, 1, 1);
        #1 chk("t5c_sys_a8", int'(bus_if.sys_a8), 1);
        bus_cycle(r); chk_cycle("t5c", r, 8, 8, 0, 0, 0, 0);
        $display("t5c ba with FE decode: csuart_low=%0d", r.cs_u);

        // Reset in the middle of a stretched UART vector cycle
        drive(0, 0, 0, 1, 0, 0);
        repeat (20) @(negedge clk);
        chk("t6_pre_eclk", int'(bus_if.eclk), 1);
        chk("t6_pre_csuart", int'(bus_if.csuart_b), 0);
        chk("t6_pre_iack", int'(bus_if.iack_b), 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_eclk", int'(bus_if.eclk), 0);
        chk("t6_qclk", int'(bus_if.qclk), 0);
        chk("t6_csuart", int'(bus_if.csuart_b), 1);
        chk("t6_csio", int'(bus_if.csio_b), 1);
        chk("t6_iack", int'(bus_if.iack_b), 1);
        chk("t6_to", int'(bus_if.stretch_to), 0);
        bus_if.sys_mrdy = 1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        bus_cycle(r); chk_cycle("t6r", r, 8, 16, 19, 0, 16, 0);
        $display("t6 after reset: e_low=%0d e_high=%0d iack_low=%0d", r.e_low, r.e_high, r.iack);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
